branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter REG_WIDTH, default `REG_WIDTH (32): operand, PC and immediate width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2: number of flush cycles after a taken branch (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port br_valid  input  1  branch request valid.
REQ-006 SHALL have port br_ready  output  1  controller can accept a request.
REQ-007 SHALL have port funct3  input  3  branch funct3 field.
REQ-008 SHALL have port rs1_in, rs2_in  input  REG_WIDTH each  source operands.
REQ-009 SHALL have port pc_in, imm_in  input  REG_WIDTH each  branch PC and sign-extended B-immediate.
REQ-010 SHALL have port kill  input  1  abort the in-flight branch.
REQ-011 SHALL have port pc_write  output  1  comparator enable.
REQ-012 SHALL have port br_un  output  1  comparator unsigned select.
REQ-013 SHALL have port data_rs1, data_rs2  output  REG_WIDTH each  registered operands to the comparator.
REQ-014 SHALL have port br_eq, br_lt  input  1 each  comparator results, combinational from data_rs1/data_rs2.
REQ-015 SHALL have port res_valid  output  1  one-cycle result strobe.
REQ-016 SHALL have port res_taken  output  1  branch taken.
REQ-017 SHALL have port res_target  output  REG_WIDTH  next PC.
REQ-018 SHALL have port res_illegal  output  1  funct3 is 010 or 011.
REQ-019 SHALL have port flush  output  1  squash younger pipeline stages.

Function
REQ-020 SHALL implement FSM states IDLE, CMP, RESP and FLUSH.
REQ-021 SHALL assert br_ready only in IDLE.
REQ-022 IDLE: br_valid && br_ready SHALL capture funct3, rs1_in, rs2_in, pc_in and imm_in into registers; next state CMP.
REQ-023 IDLE: br_valid low SHALL keep the FSM in IDLE; registers SHALL hold.
REQ-024 data_rs1/data_rs2 SHALL be driven from the captured registers at all times.
REQ-025 CMP: pc_write SHALL be 1 and br_un SHALL equal captured funct3[1].
REQ-026 CMP: br_eq/br_lt SHALL be sampled, taken decided and registered; next state RESP.
REQ-027 Taken rule SHALL be: 000 eq; 001 !eq; 100 lt; 101 !lt; 110 lt; 111 !lt; 010/011 not taken with illegal=1.
REQ-028 pc_write SHALL be 0 in all states other than CMP; br_un SHALL be 0 outside CMP.
REQ-029 RESP: res_valid SHALL be 1 for exactly one cycle, with res_taken and res_illegal registered.
REQ-030 res_target SHALL be pc+imm when taken and pc+4 otherwise, truncated to REG_WIDTH (wraps modulo 2^REG_WIDTH).
REQ-031 res_taken, res_target and res_illegal SHALL hold their values until the next RESP.
REQ-032 Latency SHALL be fixed: accept at cycle T, res_valid at T+2.
REQ-033 RESP, not taken: next state SHALL be IDLE; the earliest next accept is T+3.
REQ-034 RESP, taken: a down-counter SHALL load FLUSH_CYCLES; next state FLUSH.
REQ-035 FLUSH: flush SHALL be 1 and the counter SHALL decrement each cycle; at count 1, next state IDLE.
REQ-036 flush SHALL be high for exactly FLUSH_CYCLES consecutive cycles starting at T+3.
REQ-037 kill in CMP or RESP SHALL force IDLE next cycle; res_valid SHALL be suppressed if kill coincides with RESP.
REQ-038 kill in FLUSH SHALL NOT shorten the flush window.
REQ-039 kill in IDLE SHALL have no effect, and a simultaneous br_valid SHALL still be accepted.
REQ-040 Illegal funct3 SHALL produce res_valid with res_illegal=1, res_taken=0 and no flush.

Reset
REQ-041 rst SHALL dominate all inputs, including kill and br_valid.
REQ-042 rst SHALL force state IDLE, clear the flush counter and zero all captured registers.
REQ-043 During and after rst, outputs SHALL read: br_ready=1, pc_write=0, br_un=0, data_rs1=data_rs2=0, res_valid=0, res_taken=0, res_target=0, res_illegal=0, flush=0.
REQ-044 rst asserted mid-operation (any state) SHALL abort the branch, with no res_valid and no flush on the following cycle.

Verification
REQ-045 BEQ: rs1=5, rs2=5, pc=0x100, imm=0x20 -> res_valid at T+2, taken=1, target=0x120, flush high T+3..T+4.
REQ-046 BLT vs BLTU: rs1=0xFFFFFFFF, rs2=1 -> BLT: br_un=0 in CMP, taken=1; BLTU: br_un=1, taken=0, target=pc+4.
REQ-047 Wrap: pc=0xFFFFFFFC, imm=8, BGE rs1=rs2=0 -> taken=1, target=0x00000004; pc=0xFFFFFFFC, BNE rs1=rs2 -> target=0x00000000.
REQ-048 Illegal: funct3=010 -> res_valid=1, res_illegal=1, res_taken=0, flush never asserted, br_ready=1 at T+3.
REQ-049 Kill/reset: kill in CMP -> no res_valid, br_ready=1 next cycle; rst in FLUSH -> flush=0 and IDLE next cycle.
REQ-050 Back-to-back: br_valid held high with two not-taken BNE (rs1=rs2) -> accepts at T and T+3, res_valid at T+2 and T+5.

Source files
------------

// File: rtl/branch_ctrl.sv
// branch_ctrl: sequencing controller for a conditional branch.
//   Accepts one branch request, drives an external comparator for one cycle,
//   reports taken/target/illegal, then squashes younger stages for
//   FLUSH_CYCLES cycles when the branch is taken.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   br_valid / br_ready      request handshake (ready only in IDLE)
//   funct3, rs1_in, rs2_in   branch condition and operands
//   pc_in, imm_in            branch PC and sign-extended B-immediate
//   kill                     abort the in-flight branch (CMP/RESP only)
//   pc_write, br_un          comparator enable and unsigned select
//   data_rs1, data_rs2       captured operands to the comparator
//   br_eq, br_lt             comparator results
//   res_valid                one-cycle result strobe
//   res_taken, res_target    decision and next PC (held until next result)
//   res_illegal              funct3 was 010/011
//   flush                    squash window after a taken branch
//
// state | meaning
// IDLE  | waiting for a request, br_ready high
// CMP   | comparator enabled, decision registered at end of cycle
// RESP  | result strobe
// FLUSH | squash window, down-counter running

`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module branch_ctrl #(
    parameter int REG_WIDTH    = `REG_WIDTH,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_valid,
    output logic                 br_ready,
    input  logic [2:0]           funct3,
    input  logic [REG_WIDTH-1:0] rs1_in,
    input  logic [REG_WIDTH-1:0] rs2_in,
    input  logic [REG_WIDTH-1:0] pc_in,
    input  logic [REG_WIDTH-1:0] imm_in,
    input  logic                 kill,
    output logic                 pc_write,
    output logic                 br_un,
    output logic [REG_WIDTH-1:0] data_rs1,
    output logic [REG_WIDTH-1:0] data_rs2,
    input  logic                 br_eq,
    input  logic                 br_lt,
    output logic                 res_valid,
    output logic                 res_taken,
    output logic [REG_WIDTH-1:0] res_target,
    output logic                 res_illegal,
    output logic                 flush
);

    typedef enum logic [1:0] {IDLE, CMP, RESP, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t               state;
    logic [2:0]           f3_q;
    logic [REG_WIDTH-1:0] rs1_q;
    logic [REG_WIDTH-1:0] rs2_q;
    logic [REG_WIDTH-1:0] pc_q;
    logic [REG_WIDTH-1:0] imm_q;
    logic [3:0]           flush_cnt;
    logic                 cmp_taken;
    logic                 cmp_illegal;

    assign br_ready = (state == IDLE);
    assign pc_write = (state == CMP);
    assign br_un    = (state == CMP) && f3_q[1];
    assign flush    = (state == FLUSH);
    assign data_rs1 = rs1_q;
    assign data_rs2 = rs2_q;
    // kill landing on the RESP cycle must hide the strobe in that same cycle.
    assign res_valid = (state == RESP) && !kill;

    // funct3[2] selects the lt family, funct3[0] inverts the condition.
    always_comb begin
        cmp_illegal = (f3_q[2:1] == 2'b01);
        if (f3_q[2])
            cmp_taken = br_lt ^ f3_q[0];
        else if (f3_q[1])
            cmp_taken = 1'b0;
        else
            cmp_taken = br_eq ^ f3_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            f3_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            flush_cnt   <= '0;
            res_taken   <= 1'b0;
            res_target  <= '0;
            res_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (br_valid) begin
                        f3_q  <= funct3;
                        rs1_q <= rs1_in;
                        rs2_q <= rs2_in;
                        pc_q  <= pc_in;
                        imm_q <= imm_in;
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        res_taken   <= cmp_taken;
                        res_illegal <= cmp_illegal;
                        res_target  <= cmp_taken ? (pc_q + imm_q)
                                                 : (pc_q + REG_WIDTH'(4));
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (kill) begin
                        state <= IDLE;
                    end else if (res_taken) begin
                        flush_cnt <= FLUSH_LOAD;
                        state     <= FLUSH;
                    end else begin
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    // kill is ignored here; the window always runs to completion.
                    flush_cnt <= flush_cnt - 4'd1;
                    if (flush_cnt <= 4'd1) begin
                        flush_cnt <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

    localparam int W  = 32;
    localparam int FC = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         br_valid;
    logic         br_ready;
    logic [2:0]   funct3;
    logic [W-1:0] rs1_in, rs2_in, pc_in, imm_in;
    logic         kill;
    logic         pc_write;
    logic         br_un;
    logic [W-1:0] data_rs1, data_rs2;
    logic         br_eq, br_lt;
    logic         res_valid;
    logic         res_taken;
    logic [W-1:0] res_target;
    logic         res_illegal;
    logic         flush;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_last_target;

    always #5 clk = ~clk;

    branch_ctrl #(.REG_WIDTH(W), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
        .funct3(funct3), .rs1_in(rs1_in), .rs2_in(rs2_in),
        .pc_in(pc_in), .imm_in(imm_in), .kill(kill),
        .pc_write(pc_write), .br_un(br_un),
        .data_rs1(data_rs1), .data_rs2(data_rs2),
        .br_eq(br_eq), .br_lt(br_lt),
        .res_valid(res_valid), .res_taken(res_taken),
        .res_target(res_target), .res_illegal(res_illegal), .flush(flush)
    );

    // External comparator model.
    assign br_eq = (data_rs1 == data_rs2);
    assign br_lt = br_un ? (data_rs1 < data_rs2)
                         : ($signed(data_rs1) < $signed(data_rs2));

    typedef struct {
        logic [2:0]   f3;
        logic [W-1:0] rs1, rs2, pc, imm;
        logic         bru;
        logic         taken;
        logic         illegal;
        logic [W-1:0] target;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] p, input logic [W-1:0] i);
        funct3 = f; rs1_in = a; rs2_in = b; pc_in = p; imm_in = i;
    endtask

    // Entered at a negedge in an accept-ready cycle; leaves at a negedge with br_ready high.
    task automatic run_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        chk({s, "_ready_T"}, br_ready, 1);
        drive(v.f3, v.rs1, v.rs2, v.pc, v.imm);
        br_valid = 1'b1;
        @(negedge clk);
        br_valid = 1'b0;
        chk({s, "_pc_write"}, pc_write, 1);
        chk({s, "_br_un"}, br_un, v.bru);
        chk({s, "_data_rs1"}, data_rs1, v.rs1);
        chk({s, "_data_rs2"}, data_rs2, v.rs2);
        chk({s, "_ready_cmp"}, br_ready, 0);
        chk({s, "_early_valid"}, res_valid, 0);
        @(negedge clk);
        chk({s, "_res_valid"}, res_valid, 1);
        chk({s, "_taken"}, res_taken, v.taken);
        chk({s, "_illegal"}, res_illegal, v.illegal);
        chk({s, "_target"}, res_target, v.target);
        chk({s, "_pc_write_resp"}, pc_write, 0);
        chk({s, "_br_un_resp"}, br_un, 0);
        chk({s, "_flush_resp"}, flush, 0);
        exp_last_target = v.target;
        @(negedge clk);
        chk({s, "_valid_drop"}, res_valid, 0);
        if (v.taken) begin
            for (int k = 0; k < FC; k++) begin
                chk({s, "_flush_on"}, flush, 1);
                chk({s, "_ready_flush"}, br_ready, 0);
                chk({s, "_target_hold"}, res_target, v.target);
                @(negedge clk);
            end
        end
        chk({s, "_flush_off"}, flush, 0);
        chk({s, "_ready_after"}, br_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        //          f3      rs1           rs2           pc            imm           bru   tkn   ill   target
        vecs[0]  = '{3'b000, 32'd5,        32'd5,        32'h100,      32'h20,       1'b0, 1'b1, 1'b0, 32'h120};
        vecs[1]  = '{3'b000, 32'd5,        32'd6,        32'h100,      32'h20,       1'b0, 1'b0, 1'b0, 32'h104};
        vecs[2]  = '{3'b001, 32'd5,        32'd6,        32'h200,      32'h40,       1'b0, 1'b1, 1'b0, 32'h240};
        vecs[3]  = '{3'b100, 32'hFFFFFFFF, 32'd1,        32'h300,      32'h10,       1'b0, 1'b1, 1'b0, 32'h310};
        vecs[4]  = '{3'b110, 32'hFFFFFFFF, 32'd1,        32'h300,      32'h10,       1'b1, 1'b0, 1'b0, 32'h304};
        vecs[5]  = '{3'b101, 32'd0,        32'd0,        32'hFFFFFFFC, 32'h8,        1'b0, 1'b1, 1'b0, 32'h4};
        vecs[6]  = '{3'b001, 32'd7,        32'd7,        32'hFFFFFFFC, 32'h8,        1'b0, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{3'b010, 32'd3,        32'd3,        32'h400,      32'h40,       1'b1, 1'b0, 1'b1, 32'h404};
        vecs[8]  = '{3'b011, 32'd1,        32'd2,        32'h400,      32'h40,       1'b1, 1'b0, 1'b1, 32'h404};
        vecs[9]  = '{3'b111, 32'd1,        32'hFFFFFFFF, 32'h500,      32'h100,      1'b1, 1'b0, 1'b0, 32'h504};
        vecs[10] = '{3'b101, 32'd1,        32'hFFFFFFFF, 32'h500,      32'h100,      1'b0, 1'b1, 1'b0, 32'h600};
        vecs[11] = '{3'b100, 32'hFFFFFFFB, 32'd3,        32'h10,       32'hFFFFFFF0, 1'b0, 1'b1, 1'b0, 32'h0};

        // Reset dominates br_valid and kill.
        rst = 1'b1; kill = 1'b1; br_valid = 1'b1;
        drive(3'b000, 32'h55, 32'h55, 32'h1000, 32'h4);
        exp_last_target = '0;
        repeat (3) @(negedge clk);
        chk("rst_br_ready", br_ready, 1);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_br_un", br_un, 0);
        chk("rst_data_rs1", data_rs1, 0);
        chk("rst_data_rs2", data_rs2, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_taken", res_taken, 0);
        chk("rst_res_target", res_target, 0);
        chk("rst_res_illegal", res_illegal, 0);
        chk("rst_flush", flush, 0);
        rst = 1'b0; kill = 1'b0; br_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", br_ready, 1);
        chk("post_rst_pc_write", pc_write, 0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Idle with br_valid low: registers hold.
        repeat (3) @(negedge clk);
        chk("idle_ready", br_ready, 1);
        chk("idle_hold_rs1", data_rs1, vecs[11].rs1);
        chk("idle_hold_rs2", data_rs2, vecs[11].rs2);

        // Kill in CMP: no strobe, back to IDLE, results held.
        drive(3'b000, 32'd4, 32'd4, 32'h800, 32'h10);
        br_valid = 1'b1;
        @(negedge clk);
        br_valid = 1'b0; kill = 1'b1;
        chk("kcmp_pc_write", pc_write, 1);
        @(negedge clk);
        kill = 1'b0;
        chk("kcmp_no_valid", res_valid, 0);
        chk("kcmp_ready", br_ready, 1);
        chk("kcmp_target_hold", res_target, exp_last_target);
        @(negedge clk);
        chk("kcmp_no_valid2", res_valid, 0);
        chk("kcmp_no_flush", flush, 0);

        // Kill coinciding with RESP: strobe suppressed, no flush.
        drive(3'b000, 32'd4, 32'd4, 32'h800, 32'h10);
        br_valid = 1'b1;
        @(negedge clk);
        br_valid = 1'b0;
        @(negedge clk);
        kill = 1'b1;
        #1;
        chk("kresp_no_valid", res_valid, 0);
        @(negedge clk);
        kill = 1'b0;
        chk("kresp_no_flush", flush, 0);
        chk("kresp_ready", br_ready, 1);

        // Kill in FLUSH does not shorten the window.
        drive(3'b000, 32'd4, 32'd4, 32'h800, 32'h10);
        br_valid = 1'b1;
        @(negedge clk);
        br_valid = 1'b0;
        @(negedge clk);
        chk("kfl_valid", res_valid, 1);
        @(negedge clk);
        kill = 1'b1;
        chk("kfl_flush1", flush, 1);
        @(negedge clk);
        chk("kfl_flush2", flush, 1);
        kill = 1'b0;
        @(negedge clk);
        chk("kfl_flush_end", flush, 0);
        chk("kfl_ready", br_ready, 1);

        // Kill in IDLE is ignored and the request is still accepted.
        drive(3'b001, 32'd1, 32'd1, 32'h900, 32'h10);
        kill = 1'b1; br_valid = 1'b1;
        @(negedge clk);
        kill = 1'b0; br_valid = 1'b0;
        chk("kidle_pc_write", pc_write, 1);
        @(negedge clk);
        chk("kidle_valid", res_valid, 1);
        chk("kidle_taken", res_taken, 0);
        chk("kidle_target", res_target, 32'h904);
        @(negedge clk);
        chk("kidle_ready", br_ready, 1);

        // Reset in FLUSH: window ends immediately, everything cleared.
        drive(3'b000, 32'd8, 32'd8, 32'hA00, 32'h30);
        br_valid = 1'b1;
        @(negedge clk);
        br_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rfl_flush_on", flush, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rfl_flush_off", flush, 0);
        chk("rfl_ready", br_ready, 1);
        chk("rfl_data_rs1", data_rs1, 0);
        chk("rfl_target", res_target, 0);
        chk("rfl_taken", res_taken, 0);
        @(negedge clk);
        chk("rfl_flush_off2", flush, 0);

        // Reset in CMP: no strobe afterwards.
        drive(3'b000, 32'd8, 32'd8, 32'hA00, 32'h30);
        br_valid = 1'b1;
        @(negedge clk);
        br_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rcmp_no_valid", res_valid, 0);
        chk("rcmp_ready", br_ready, 1);
        @(negedge clk);
        chk("rcmp_no_valid2", res_valid, 0);

        // Back-to-back not-taken BNE with br_valid held: accepts at T and T+3.
        begin
            logic exp_rv[7];
            logic exp_pw[7];
            logic exp_rdy[7];
            exp_rv  = '{0, 0, 1, 0, 0, 1, 0};
            exp_pw  = '{0, 1, 0, 0, 1, 0, 0};
            exp_rdy = '{1, 0, 0, 1, 0, 0, 1};
            drive(3'b001, 32'd9, 32'd9, 32'h700, 32'h80);
            br_valid = 1'b1;
            for (int c = 0; c < 7; c++) begin
                if (c == 5) br_valid = 1'b0;
                chk($sformatf("b2b_valid_c%0d", c), res_valid, exp_rv[c]);
                chk($sformatf("b2b_pc_write_c%0d", c), pc_write, exp_pw[c]);
                chk($sformatf("b2b_ready_c%0d", c), br_ready, exp_rdy[c]);
                if (exp_rv[c]) chk($sformatf("b2b_target_c%0d", c), res_target, 32'h704);
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
